// File: rtl/ex_pkg.sv
// Shared types and defaults for the execute stage.
package ex_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned MUL_CYCLES_DEF = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_MUL   = 4'd11,
    ALU_MULHU = 4'd12
  } alu_ops_t;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2,
    FWD_RSVD = 2'd3
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/ex_if.sv
// ID/EX-to-EX/MEM bus of the execute stage; master drives operands, slave is the stage.
interface ex_if
  import ex_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) ();
  logic                  flush_ex;
  alu_ops_t              ALUOp;
  logic                  ALUSrc;
  logic                  Branch;
  logic [ADDR_WIDTH-1:0] PC_in;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [DATA_WIDTH-1:0] imm;
  fwd_sel_t              fwd_a_sel;
  fwd_sel_t              fwd_b_sel;
  logic [DATA_WIDTH-1:0] mem_fwd_data;
  logic [DATA_WIDTH-1:0] wb_fwd_data;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] store_data;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  ex_busy;

  modport master (
    output flush_ex, ALUOp, ALUSrc, Branch, PC_in, rs1_data, rs2_data, imm,
           fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
    input  alu_result, store_data, branch_taken, branch_target, ex_busy
  );

  modport slave (
    input  flush_ex, ALUOp, ALUSrc, Branch, PC_in, rs1_data, rs2_data, imm,
           fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
    output alu_result, store_data, branch_taken, branch_target, ex_busy
  );
endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per RUN cycle.
// Optional early termination when EX_MUL_EARLY_OUT_EN is defined.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  mul_state_t            state_q, state_d;
  logic [PW-1:0]         acc_q, acc_d;
  logic [PW-1:0]         mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state and shift-add datapath; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy     = 1'b1;
          acc_d    = '0;
          mcand_d  = PW'(op_a);
          mplier_d = op_b;
          cnt_d    = CW'(MUL_CYCLES - 1);
          state_d  = RUN;
`ifdef EX_MUL_EARLY_OUT_EN
          if (op_b == '0) state_d = DONE;
`endif
        end
      end
      RUN: begin
        busy = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
`ifdef EX_MUL_EARLY_OUT_EN
        if ((mplier_q >> 1) == '0) state_d = DONE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      busy    = 1'b0;
    end
  end

  assign done    = (state_q == DONE);
  assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and iterative multiply.
// Build option EX_MUL_EARLY_OUT_EN shortens multiplies with small B operands.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF
) (
  input logic clk,
  input logic reset_n,
  ex_if.slave ex
);
  logic [DATA_WIDTH-1:0]   op_a, fwd_b, op_b, alu_c;
  logic [4:0]              shamt;
  logic                    lt_s, lt_u, cond_c;
  logic                    mul_start, mul_busy, mul_done, mul_valid;
  logic [2*DATA_WIDTH-1:0] product;

  // Forwarding muxes; the reserved select falls back to the register file.
  always_comb begin
    case (ex.fwd_a_sel)
      FWD_MEM: op_a = ex.mem_fwd_data;
      FWD_WB:  op_a = ex.wb_fwd_data;
      default: op_a = ex.rs1_data;
    endcase
    case (ex.fwd_b_sel)
      FWD_MEM: fwd_b = ex.mem_fwd_data;
      FWD_WB:  fwd_b = ex.wb_fwd_data;
      default: fwd_b = ex.rs2_data;
    endcase
  end

  assign op_b      = ex.ALUSrc ? ex.imm : fwd_b;
  assign shamt     = op_b[4:0];
  assign lt_s      = $signed(op_a) < $signed(op_b);
  assign lt_u      = op_a < op_b;
  assign mul_start = (ex.ALUOp == ALU_MUL) || (ex.ALUOp == ALU_MULHU);
  assign mul_valid = mul_done && !ex.flush_ex;

  ex_mul_iter #(
    .DATA_WIDTH(DATA_WIDTH),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (mul_start),
    .flush  (ex.flush_ex),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(product)
  );

  // Single-cycle ALU; multiply ops show zero until the product is ready.
  always_comb begin
    case (ex.ALUOp)
      ALU_ADD:   alu_c = op_a + op_b;
      ALU_SUB:   alu_c = op_a - op_b;
      ALU_AND:   alu_c = op_a & op_b;
      ALU_OR:    alu_c = op_a | op_b;
      ALU_XOR:   alu_c = op_a ^ op_b;
      ALU_SLL:   alu_c = op_a << shamt;
      ALU_SRL:   alu_c = op_a >> shamt;
      ALU_SRA:   alu_c = DATA_WIDTH'($signed(op_a) >>> shamt);
      ALU_SLT:   alu_c = DATA_WIDTH'(lt_s);
      ALU_SLTU:  alu_c = DATA_WIDTH'(lt_u);
      ALU_PASSB: alu_c = op_b;
      ALU_MUL:   alu_c = mul_valid ? product[DATA_WIDTH-1:0] : '0;
      ALU_MULHU: alu_c = mul_valid ? product[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
      default:   alu_c = '0;
    endcase
  end

  // Branch condition keyed off the compare-style ALU op.
  always_comb begin
    case (ex.ALUOp)
      ALU_SUB:  cond_c = (op_a == op_b);
      ALU_XOR:  cond_c = (op_a != op_b);
      ALU_SLT:  cond_c = lt_s;
      ALU_SLTU: cond_c = lt_u;
      default:  cond_c = 1'b0;
    endcase
  end

  assign ex.alu_result    = alu_c;
  assign ex.store_data    = fwd_b;
  assign ex.branch_taken  = ex.Branch && cond_c && !mul_busy;
  assign ex.branch_target = ex.PC_in + ADDR_WIDTH'(ex.imm);
  assign ex.ex_busy       = mul_busy;

endmodule
